// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package riscv_mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_F,
      WAIT_D
   } arb_state_t;

   localparam logic [31:0] NOP_INSTR           = 32'h00000013;
   localparam int          ARB_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Wait-cycle counter bounding an outstanding memory transaction.
module mem_timeout_ctr
   import riscv_mem_pkg::*;
#(
   parameter int TIMEOUT_CYC = ARB_TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int              CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count_reg <= '0;
      end else if (enable && (count_reg != LAST)) begin
         count_reg <= count_reg + CNT_W'(1);
      end
   end

   // Fires in the wait cycle whose increment would bring the count to TIMEOUT_CYC,
   // which is exactly TIMEOUT_CYC cycles after the grant.
   assign expired = enable && (count_reg == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and MEM-stage data access,
// with one transaction outstanding, flush-kill of fetch responses and a timeout.
module mem_port_arbiter
   import riscv_mem_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = ARB_TIMEOUT_DEFAULT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                f_req,
   input  logic [ADDR_W-1:0]   f_addr,
   input  logic                f_kill,
   output logic                f_rvalid,
   output logic [DATA_W-1:0]   f_rdata,
   output logic                f_err,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_wstrb,
   output logic                d_rvalid,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_err,
   output logic                fetch_stall,
   output logic                data_stall,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wstrb,
   input  logic                mem_gnt,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata
);

   arb_state_t state_reg, state_next;
   logic       kill_reg, kill_next;
   logic       grant;
   logic       ctr_en;
   logic       expired;

   assign grant  = (state_reg == IDLE) && (d_req || f_req) && mem_gnt;
   assign ctr_en = (state_reg != IDLE) && !mem_rvalid;

   mem_timeout_ctr #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clear   (grant),
      .enable  (ctr_en),
      .expired (expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         kill_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         kill_reg  <= kill_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      kill_next  = kill_reg;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_wstrb  = '0;
      f_rvalid   = 1'b0;
      f_rdata    = '0;
      f_err      = 1'b0;
      d_rvalid   = 1'b0;
      d_rdata    = '0;
      d_err      = 1'b0;

      case (state_reg)
         IDLE: begin
            kill_next = 1'b0;
            // Data wins: it belongs to the older instruction in the pipeline.
            if (d_req) begin
               mem_req   = 1'b1;
               mem_we    = d_we;
               mem_addr  = d_addr;
               mem_wdata = d_wdata;
               mem_wstrb = d_wstrb;
               if (mem_gnt) state_next = WAIT_D;
            end else if (f_req) begin
               mem_req  = 1'b1;
               mem_addr = f_addr;
               if (mem_gnt) begin
                  state_next = WAIT_F;
                  kill_next  = f_kill;
               end
            end
         end

         WAIT_F: begin
            if (mem_rvalid || expired) begin
               state_next = IDLE;
               kill_next  = 1'b0;
               // A flush in the completion cycle itself also drops the response.
               if (!(kill_reg || f_kill)) begin
                  f_rvalid = 1'b1;
                  f_err    = !mem_rvalid;
                  f_rdata  = mem_rvalid ? mem_rdata : DATA_W'(NOP_INSTR);
               end
            end else if (f_kill) begin
               kill_next = 1'b1;
            end
         end

         WAIT_D: begin
            if (mem_rvalid || expired) begin
               state_next = IDLE;
               kill_next  = 1'b0;
               d_rvalid   = 1'b1;
               d_err      = !mem_rvalid;
               d_rdata    = mem_rvalid ? mem_rdata : '0;
            end
         end

         default: begin
            state_next = IDLE;
            kill_next  = 1'b0;
         end
      endcase
   end

   assign fetch_stall = f_req && !f_rvalid;
   assign data_stall  = d_req && !d_rvalid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus randomized traffic checked against a cycle-level
// reference model of the arbitration rules.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;
   localparam logic [31:0] MODEL_NOP = 32'h00000013;

   logic          clk = 1'b0;
   logic          reset;
   logic          f_req, f_kill, d_req, d_we, mem_gnt, mem_rvalid;
   logic [AW-1:0] f_addr, d_addr, mem_addr;
   logic [DW-1:0] d_wdata, mem_rdata, f_rdata, d_rdata, mem_wdata;
   logic [3:0]    d_wstrb, mem_wstrb;
   logic          f_rvalid, f_err, d_rvalid, d_err, fetch_stall, data_stall, mem_req, mem_we;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .reset(reset),
      .f_req(f_req), .f_addr(f_addr), .f_kill(f_kill),
      .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_err(f_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .fetch_stall(fetch_stall), .data_stall(data_stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: is a transaction outstanding, who owns it, was it
   // flushed, and how many cycles have elapsed since its grant.
   bit  m_busy = 0, m_owner_d = 0, m_dropped = 0;
   int  m_age = 0;
   bit  e_f_rv, e_d_rv;
   logic obs_f_rv, obs_d_rv, obs_f_err, obs_d_err;
   logic [31:0] obs_f_rd, obs_d_rd;

   // Inputs are driven 1 ns after a rising edge; outputs are sampled mid-cycle.
   task automatic step();
      bit          e_req, e_we, grant, done, err, e_f_err, e_d_err;
      logic [31:0] e_addr, e_f_rd, e_d_rd;
      logic [3:0]  e_wstrb;
      #4;
      e_req = 0; e_we = 0; e_addr = 0; e_wstrb = 0; grant = 0; done = 0; err = 0;
      e_f_rv = 0; e_d_rv = 0; e_f_err = 0; e_d_err = 0; e_f_rd = 0; e_d_rd = 0;
      if (!m_busy) begin
         e_req = d_req || f_req;
         if (d_req) begin
            e_we = d_we; e_addr = d_addr; e_wstrb = d_wstrb;
         end else begin
            e_addr = f_addr;
         end
         grant = e_req && mem_gnt;
      end else begin
         done = mem_rvalid || (m_age + 1 == TO);
         if (done) begin
            err = !mem_rvalid;
            if (m_owner_d) begin
               e_d_rv = 1; e_d_err = err; e_d_rd = mem_rvalid ? mem_rdata : 32'h0;
            end else if (!m_dropped && !f_kill) begin
               e_f_rv = 1; e_f_err = err; e_f_rd = mem_rvalid ? mem_rdata : MODEL_NOP;
            end
         end
      end
      obs_f_rv = f_rvalid; obs_d_rv = d_rvalid; obs_f_err = f_err; obs_d_err = d_err;
      obs_f_rd = f_rdata;  obs_d_rd = d_rdata;

      check_val("mem_req", mem_req, e_req);
      if (e_req) begin
         check_val("mem_we", mem_we, e_we);
         check_val("mem_addr", mem_addr, e_addr);
         check_val("mem_wstrb", mem_wstrb, e_wstrb);
         if (d_req) check_val("mem_wdata", mem_wdata, d_wdata);
      end
      check_val("f_rvalid", f_rvalid, e_f_rv);
      check_val("f_rdata", f_rdata, e_f_rd);
      check_val("f_err", f_err, e_f_err);
      check_val("d_rvalid", d_rvalid, e_d_rv);
      check_val("d_rdata", d_rdata, e_d_rd);
      check_val("d_err", d_err, e_d_err);
      check_val("fetch_stall", fetch_stall, f_req && !e_f_rv);
      check_val("data_stall", data_stall, d_req && !e_d_rv);

      if (reset) begin
         m_busy = 0; m_dropped = 0; m_age = 0;
      end else if (!m_busy) begin
         if (grant) begin
            m_busy = 1; m_owner_d = d_req; m_dropped = !d_req && f_kill; m_age = 0;
         end
      end else if (done) begin
         m_busy = 0; m_dropped = 0;
      end else begin
         m_age++;
         if (!m_owner_d && f_kill) m_dropped = 1;
      end
      @(posedge clk);
      #1;
   endtask

   int rv_at;

   initial begin
      reset = 1; f_req = 0; f_addr = 0; f_kill = 0; d_req = 0; d_we = 0; d_addr = 0;
      d_wdata = 0; d_wstrb = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
      @(posedge clk); #1;
      step();
      check_val("rst_mem_req", mem_req, 1'b0);
      check_val("rst_f_rvalid", f_rvalid, 1'b0);
      check_val("rst_d_rvalid", d_rvalid, 1'b0);
      check_val("rst_stalls", {fetch_stall, data_stall}, 2'b00);
      reset = 0;

      // Fetch only, best-case latency
      f_req = 1; f_addr = 32'h10; mem_gnt = 1;
      step();
      mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h00500093;
      step();
      check_val("fo_rvalid", obs_f_rv, 1'b1);
      check_val("fo_rdata", obs_f_rd, 32'h00500093);
      f_req = 0; mem_rvalid = 0;
      step();

      // Contention: store first, fetch afterwards
      f_req = 1; f_addr = 32'h14; d_req = 1; d_we = 1; d_addr = 32'h100;
      d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF; mem_gnt = 1;
      step();
      mem_rvalid = 1; mem_rdata = 32'h0;
      step();
      check_val("ct_d_rvalid", obs_d_rv, 1'b1);
      d_req = 0; d_we = 0; mem_rvalid = 0;
      step();
      mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h00000297;
      step();
      check_val("ct_f_rdata", obs_f_rd, 32'h00000297);
      f_req = 0; mem_rvalid = 0;
      step();

      // Kill during WAIT_F, then a normal fetch
      f_req = 1; f_addr = 32'h20; mem_gnt = 1;
      step();
      mem_gnt = 0; f_kill = 1;
      step();
      f_kill = 0;
      step();
      mem_rvalid = 1; mem_rdata = 32'h11111111;
      step();
      check_val("kill_drop", obs_f_rv, 1'b0);
      mem_rvalid = 0; mem_gnt = 1;
      step();
      mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h22222222;
      step();
      check_val("kill_next_fetch", obs_f_rv, 1'b1);
      f_req = 0; mem_rvalid = 0;
      step();

      // Timeout of a data load, then a stray response in IDLE
      d_req = 1; d_we = 0; d_addr = 32'h40; mem_gnt = 1;
      step();
      mem_gnt = 0; rv_at = -1;
      for (int k = 1; k <= 6; k++) begin
         if (k == 5) d_req = 0;
         if (k == 6) begin mem_rvalid = 1; mem_rdata = 32'hABCD0000; end
         step();
         if (obs_d_rv === 1'b1 && rv_at < 0) begin
            rv_at = k;
            check_val("to_err", obs_d_err, 1'b1);
            check_val("to_rdata", obs_d_rd, 32'h0);
         end
      end
      check_val("to_latency", rv_at, TO);
      mem_rvalid = 0;

      // Backpressure: request held with no grant
      d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'h12345678; d_wstrb = 4'h3;
      for (int k = 0; k < 5; k++) step();
      mem_gnt = 1;
      step();
      mem_gnt = 0; mem_rvalid = 1;
      step();
      check_val("bp_done", obs_d_rv, 1'b1);
      d_req = 0; mem_rvalid = 0;
      step();

      // Reset while waiting for data
      d_req = 1; d_we = 0; d_addr = 32'hC0; mem_gnt = 1;
      step();
      reset = 1; mem_gnt = 0;
      step();
      reset = 0; d_req = 0; mem_rvalid = 1;
      step();
      check_val("rst_mid_drop", obs_d_rv, 1'b0);
      mem_rvalid = 0;
      step();

      // Randomized traffic with protocol-compliant requesters
      for (int i = 0; i < 3000; i++) begin
         if (!f_req || e_f_rv || f_kill) begin
            f_req  = ($urandom_range(0, 3) != 0);
            f_addr = $urandom & 32'hFFFF_FFFC;
         end
         if (!d_req || e_d_rv) begin
            d_req   = ($urandom_range(0, 1) != 0);
            d_we    = $urandom_range(0, 1);
            d_addr  = $urandom;
            d_wdata = $urandom;
            d_wstrb = 4'($urandom_range(0, 15));
         end
         f_kill     = ($urandom_range(0, 19) == 0);
         mem_gnt    = ($urandom_range(0, 3) != 0);
         mem_rvalid = ($urandom_range(0, 9) < 3);
         mem_rdata  = $urandom;
         reset      = ($urandom_range(0, 199) == 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
